// File: rtl/am_argmax_pipe.sv
// am_argmax_pipe: pipelined argmax over NUM_CLASSES unsigned similarity
// scores. Returns the winning class (lowest index on ties), its score, the
// margin to the true runner-up, and a low-confidence flag against a
// per-vector threshold.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready = global advance)
//   sim_values     NUM_CLASSES x SIM_W scores, element i is class i
//   margin_thresh  threshold captured with the vector
//   out_valid/out_ready   output handshake
//   out_class, out_best, out_margin, out_low_conf  registered result,
//                  held after consumption until the next result loads
module am_argmax_pipe #(
    parameter int NUM_CLASSES = 26,
    parameter int SIM_W       = 13,
    parameter int CLASS_W     = $clog2(NUM_CLASSES),
    parameter int REG_EVERY   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SIM_W*NUM_CLASSES-1:0]   sim_values,
    input  logic [SIM_W-1:0]               margin_thresh,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CLASS_W-1:0]             out_class,
    output logic [SIM_W-1:0]               out_best,
    output logic [SIM_W-1:0]               out_margin,
    output logic                           out_low_conf
);

    localparam int unsigned NC = NUM_CLASSES;
    localparam int unsigned L  = $clog2(NUM_CLASSES);
    localparam int unsigned NL = 1 << L;
    localparam int unsigned RE = REG_EVERY;

    // Level k is followed by a register when k is a multiple of REG_EVERY
    // or is the root; the root register is the output register.
    function automatic logic lvl_reg(input int unsigned k);
        return (k != 0) && (((k % RE) == 0) || (k == L));
    endfunction

    // Combinational view of every tree level (level 0 = leaves).
    logic [SIM_W-1:0]   c_bv  [0:L][0:NL-1];
    logic [SIM_W-1:0]   c_sv  [0:L][0:NL-1];
    logic [CLASS_W-1:0] c_bi  [0:L][0:NL-1];
    logic               c_ok  [0:L][0:NL-1];
    logic               c_vld [0:L];
    logic [SIM_W-1:0]   c_thr [0:L];

    // Registered copies; only levels with lvl_reg() below the root are used.
    logic [SIM_W-1:0]   bv_q  [0:L][0:NL-1];
    logic [SIM_W-1:0]   sv_q  [0:L][0:NL-1];
    logic [CLASS_W-1:0] bi_q  [0:L][0:NL-1];
    logic               ok_q  [0:L][0:NL-1];
    logic               vld_q [0:L];
    logic [SIM_W-1:0]   thr_q [0:L];

    logic               out_valid_q;
    logic [CLASS_W-1:0] out_class_q;
    logic [SIM_W-1:0]   out_best_q;
    logic [SIM_W-1:0]   out_margin_q;
    logic               out_low_conf_q;
    logic [SIM_W-1:0]   margin_d;
    logic               low_conf_d;
    logic               advance;

    assign advance      = !out_valid_q || out_ready;
    assign in_ready     = advance;
    assign out_valid    = out_valid_q;
    assign out_class    = out_class_q;
    assign out_best     = out_best_q;
    assign out_margin   = out_margin_q;
    assign out_low_conf = out_low_conf_q;

    always_comb begin
        logic [SIM_W-1:0]   a_bv, a_sv, b_bv, b_sv, l_bv, w_sv;
        logic [CLASS_W-1:0] a_bi, b_bi;
        logic               a_ok, b_ok, a_win, src_reg;
        a_bv = '0; a_sv = '0; b_bv = '0; b_sv = '0; l_bv = '0; w_sv = '0;
        a_bi = '0; b_bi = '0; a_ok = 1'b0; b_ok = 1'b0; a_win = 1'b0;
        src_reg = 1'b0;
        for (int unsigned k = 0; k <= L; k++) begin
            c_vld[k] = 1'b0;
            c_thr[k] = '0;
            for (int unsigned i = 0; i < NL; i++) begin
                c_bv[k][i] = '0;
                c_sv[k][i] = '0;
                c_bi[k][i] = '0;
                c_ok[k][i] = 1'b0;
            end
        end

        // Leaves: pad leaves beyond NUM_CLASSES stay invalid.
        for (int unsigned i = 0; i < NL; i++) begin
            c_bi[0][i] = CLASS_W'(i);
            if (i < NC) begin
                c_bv[0][i] = sim_values[i*SIM_W +: SIM_W];
                c_ok[0][i] = 1'b1;
            end
        end
        c_vld[0] = in_valid;
        c_thr[0] = margin_thresh;

        for (int unsigned k = 1; k <= L; k++) begin
            src_reg  = lvl_reg(k - 1);
            c_vld[k] = src_reg ? vld_q[k-1] : c_vld[k-1];
            c_thr[k] = src_reg ? thr_q[k-1] : c_thr[k-1];
            for (int unsigned i = 0; i < (NL >> k); i++) begin
                if (src_reg) begin
                    a_bv = bv_q[k-1][2*i];   a_sv = sv_q[k-1][2*i];
                    a_bi = bi_q[k-1][2*i];   a_ok = ok_q[k-1][2*i];
                    b_bv = bv_q[k-1][2*i+1]; b_sv = sv_q[k-1][2*i+1];
                    b_bi = bi_q[k-1][2*i+1]; b_ok = ok_q[k-1][2*i+1];
                end else begin
                    a_bv = c_bv[k-1][2*i];   a_sv = c_sv[k-1][2*i];
                    a_bi = c_bi[k-1][2*i];   a_ok = c_ok[k-1][2*i];
                    b_bv = c_bv[k-1][2*i+1]; b_sv = c_sv[k-1][2*i+1];
                    b_bi = c_bi[k-1][2*i+1]; b_ok = c_ok[k-1][2*i+1];
                end
                // Left (lower indices) wins ties; an invalid loser adds nothing.
                a_win = !b_ok || (a_ok && (a_bv >= b_bv));
                if (a_win) begin
                    c_bv[k][i] = a_bv;
                    c_bi[k][i] = a_bi;
                    w_sv       = a_sv;
                    l_bv       = b_ok ? b_bv : '0;
                end else begin
                    c_bv[k][i] = b_bv;
                    c_bi[k][i] = b_bi;
                    w_sv       = b_sv;
                    l_bv       = a_ok ? a_bv : '0;
                end
                c_sv[k][i] = (l_bv > w_sv) ? l_bv : w_sv;
                c_ok[k][i] = a_ok || b_ok;
            end
        end

        margin_d   = c_bv[L][0] - c_sv[L][0];
        low_conf_d = margin_d < c_thr[L];
    end

    // Data registers load only with a valid vector so the output keeps its
    // last result while bubbles pass through.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_class_q    <= '0;
            out_best_q     <= '0;
            out_margin_q   <= '0;
            out_low_conf_q <= 1'b0;
            for (int unsigned k = 0; k <= L; k++) begin
                vld_q[k] <= 1'b0;
                thr_q[k] <= '0;
                for (int unsigned i = 0; i < NL; i++) begin
                    bv_q[k][i] <= '0;
                    sv_q[k][i] <= '0;
                    bi_q[k][i] <= '0;
                    ok_q[k][i] <= 1'b0;
                end
            end
        end else if (advance) begin
            for (int unsigned k = 1; k < L; k++) begin
                if (lvl_reg(k)) begin
                    vld_q[k] <= c_vld[k];
                    if (c_vld[k]) begin
                        thr_q[k] <= c_thr[k];
                        for (int unsigned i = 0; i < (NL >> k); i++) begin
                            bv_q[k][i] <= c_bv[k][i];
                            sv_q[k][i] <= c_sv[k][i];
                            bi_q[k][i] <= c_bi[k][i];
                            ok_q[k][i] <= c_ok[k][i];
                        end
                    end
                end
            end
            out_valid_q <= c_vld[L];
            if (c_vld[L]) begin
                out_class_q    <= c_bi[L][0];
                out_best_q     <= c_bv[L][0];
                out_margin_q   <= margin_d;
                out_low_conf_q <= low_conf_d;
            end
        end
    end

endmodule
